nonce_tx_arbiter: RTL and testbench
===================================

# nonce_tx_arbiter

Shares one `serial_transmit` word channel between `NUM_CORES` hashing cores that report golden nonces. Each core gets a one-entry holding register. A round-robin arbiter moves pending nonces into a small FIFO. A transmit FSM pops the FIFO and drives the `send`/`busy` handshake of `serial_transmit`, one 32-bit word per nonce. The block sits between the core array and the UART transmit path in the miner top level.

## Interface
Parameters:
- `NUM_CORES`, 4: number of requesting cores, 1..16.
- `FIFO_DEPTH`, 8: nonce FIFO entries; must be a power of 2, at least 2.
- `NONCE_ADJ`, 32'd0: constant subtracted from every nonce before transmit, to compensate for core pipeline depth.

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: synchronous, active-high.
- `nonce_vld`, in, `NUM_CORES`: per-core one-cycle pulse, "golden nonce found".
- `nonce_in`, in, 32*`NUM_CORES`: core i's nonce on bits [32i+31:32i]; sampled only when `nonce_vld[i]` is high.
- `tx_busy`, in, 1: `busy` from `serial_transmit`.
- `tx_send`, out, 1: one-cycle `send` strobe to `serial_transmit`.
- `tx_word`, out, 32: word to send; held stable from the `tx_send` cycle until the FSM returns to IDLE.
- `overflow`, out, 1: sticky flag, set when any nonce is dropped.
- `fifo_count`, out, log2(`FIFO_DEPTH`)+1: current FIFO occupancy.

## Operation
- Hold registers: `pend[i]` and `hold[i]`.
  - `nonce_vld[i]` with `pend[i]`=0: capture `nonce_in` slice, set `pend[i]`.
  - `nonce_vld[i]` with `pend[i]`=1 and core i not granted this cycle: drop the new nonce, set `overflow`.
  - `nonce_vld[i]` in the same cycle core i is granted: the granted value goes to the FIFO and the new value is captured. No drop.
- Arbiter, when the FIFO is not full:
  - Grants the lowest pending index strictly after `last_grant`, wrapping modulo `NUM_CORES`.
  - Writes `hold[g] - NONCE_ADJ` (mod 2^32) into the FIFO, clears `pend[g]`, sets `last_grant`=g.
  - At most one grant per cycle.
- FIFO full: no grant. Holds stay pending and `overflow` is unaffected.
- FIFO push and pop in the same cycle are both allowed. A push when full cannot happen because the arbiter is gated.
- Transmit FSM states:
  - IDLE: if FIFO not empty and `tx_busy`=0, pop to `tx_word` and go to SEND.
  - SEND: `tx_send`=1 for exactly one cycle, then go to WAIT_BUSY.
  - WAIT_BUSY: wait for `tx_busy`=1, then go to WAIT_DONE.
  - WAIT_DONE: wait for `tx_busy`=0, then go to IDLE.
- WAIT_BUSY timeout: if `tx_busy` never rises within 4 cycles, go to IDLE. This covers the transmitter missing the strobe; the word is lost and `overflow` is set.
- Reset values:
  - FSM in IDLE, FIFO empty, all `pend`=0.
  - `last_grant`=`NUM_CORES`-1, so core 0 wins the first round.
  - `tx_send`=0, `tx_word`=0, `overflow`=0, `fifo_count`=0.
- Reset mid-transmission forces IDLE and empties the FIFO. `serial_transmit` may still finish the word it already accepted; this is acceptable.

## Timing
- Latency with an idle system, `nonce_vld[i]` high at edge k:
  - `pend[i]` is set after edge k.
  - FIFO write at edge k+1.
  - Pop and `tx_send` rise at edge k+2.
  - `tx_send` falls at edge k+3.
- `serial_transmit` raises `busy` one cycle after `send`; WAIT_BUSY covers that gap.
- Throughput: one word per `serial_transmit` cycle of 4 bytes plus wait states. The FIFO absorbs bursts.
- `fifo_count` is registered and updates on the edge after a push or pop.

## Structure
- Shared miner package holds:
  - the FSM state encoding (IDLE/SEND/WAIT_BUSY/WAIT_DONE);
  - the nonce width constant (32);
  - the timeout constant (4).
- One sub-module, `nonce_fifo`:
  - synchronous FIFO with width 32 and depth `FIFO_DEPTH`;
  - uses `full`/`empty`/`count` and an extra wrap bit on the pointers.
- Arbiter and hold registers stay inline.

## Test plan
- Single nonce: core 2 pulses 32'h12345678 with `NONCE_ADJ`=0 → one `tx_send` pulse 2 edges later with `tx_word`=32'h12345678; `overflow`=0.
- Adjustment wrap: `NONCE_ADJ`=5, nonce 32'h00000002 → `tx_word`=32'hFFFFFFFD.
- Round-robin: all 4 cores pulse in the same cycle with values A,B,C,D → transmitted in order A,B,C,D. A second simultaneous burst → order A,B,C,D again, since the pointer rotates from 3.
- Full FIFO: `tx_busy` held high, 12 nonces from alternating cores → `fifo_count` reaches 8 and the hold registers fill. A further pulse on a pending core sets `overflow`. After release, exactly 8 + `NUM_CORES` words go out with no duplicates.
- Missed strobe: `tx_busy` stuck at 0 after `tx_send` → return to IDLE after 4 cycles, `overflow`=1, and the next FIFO word is sent.
- Reset mid-transmit in WAIT_DONE with 3 entries queued → next cycle `tx_send`=0, `fifo_count`=0, all `pend`=0; a fresh nonce then goes out with normal latency.

Source files
------------

// File: rtl/nonce_tx_arbiter_pkg.sv
// Shared miner constants and the transmit FSM state encoding used by the nonce
// arbiter and its FIFO.
package nonce_tx_arbiter_pkg;

  localparam int NONCE_W      = 32;
  localparam int BUSY_TIMEOUT = 4;
  localparam int TIMEOUT_W    = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    TX_IDLE      = 2'd0,
    TX_SEND      = 2'd1,
    TX_WAIT_BUSY = 2'd2,
    TX_WAIT_DONE = 2'd3
  } tx_state_t;

endpackage

// File: rtl/nonce_fifo.sv
// Synchronous nonce FIFO; pointers carry an extra wrap bit so full and empty
// are told apart without a separate counter.
module nonce_fifo
  import nonce_tx_arbiter_pkg::*;
#(
  parameter int WIDTH = NONCE_W,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign pop_data = mem[rd_ptr[AW-1:0]];
  assign count    = wr_ptr - rd_ptr;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/nonce_tx_arbiter.sv
// Collects golden nonces from the core array, round-robins them into a FIFO and
// feeds them one 32-bit word at a time to serial_transmit via send/busy.
module nonce_tx_arbiter
  import nonce_tx_arbiter_pkg::*;
#(
  parameter int                  NUM_CORES  = 4,
  parameter int                  FIFO_DEPTH = 8,
  parameter logic [NONCE_W-1:0]  NONCE_ADJ  = 32'd0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_CORES-1:0]           nonce_vld,
  input  logic [NONCE_W*NUM_CORES-1:0]   nonce_in,
  input  logic                           tx_busy,
  output logic                           tx_send,
  output logic [NONCE_W-1:0]             tx_word,
  output logic                           overflow,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
  output logic [1:0]                     tx_state
);

  localparam int GW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic [NUM_CORES-1:0] pend;
  logic [NONCE_W-1:0]   hold [NUM_CORES];
  logic [GW-1:0]        last_grant;
  logic [GW-1:0]        grant_idx;
  logic [GW-1:0]        cand_idx;
  logic                 grant_found;
  logic                 grant_vld;
  logic [NUM_CORES-1:0] grant_mask;
  logic [NUM_CORES-1:0] capture;
  logic                 drop_any;
  int                   cand;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_pop;
  logic [NONCE_W-1:0]   fifo_rdata;
  logic [NONCE_W-1:0]   push_data;

  tx_state_t            state;
  tx_state_t            state_next;
  logic [TIMEOUT_W-1:0] wait_cnt;
  logic [TIMEOUT_W-1:0] wait_cnt_next;
  logic                 timeout_hit;

  // Scan from the farthest candidate down so the nearest pending core after
  // last_grant is the final (winning) assignment.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = last_grant;
    cand        = 0;
    cand_idx    = '0;
    for (int off = NUM_CORES; off >= 1; off--) begin
      cand = int'(last_grant) + off;
      if (cand >= NUM_CORES) cand = cand - NUM_CORES;
      cand_idx = GW'(cand);
      if (pend[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  assign grant_vld  = grant_found && !fifo_full;
  assign grant_mask = grant_vld ? (NUM_CORES'(1) << grant_idx) : '0;
  assign capture    = nonce_vld & ~(pend & ~grant_mask);
  assign drop_any   = |(nonce_vld & pend & ~grant_mask);
  assign push_data  = hold[grant_idx] - NONCE_ADJ;

  always_ff @(posedge clk) begin
    if (reset) begin
      pend       <= '0;
      last_grant <= GW'(NUM_CORES - 1);
    end else begin
      pend <= (pend & ~grant_mask) | nonce_vld;
      if (grant_vld) last_grant <= grant_idx;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CORES; i++) begin
      if (capture[i]) hold[i] <= nonce_in[NONCE_W*i +: NONCE_W];
    end
  end

  nonce_fifo #(
    .WIDTH (NONCE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (grant_vld),
    .push_data (push_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= TX_IDLE;
      wait_cnt <= '0;
      tx_word  <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (fifo_pop) tx_word <= fifo_rdata;
      if (drop_any || timeout_hit) overflow <= 1'b1;
    end
  end

  // A missed strobe leaves busy low; give up after BUSY_TIMEOUT cycles and
  // count the word as lost.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    fifo_pop      = 1'b0;
    tx_send       = 1'b0;
    timeout_hit   = 1'b0;
    case (state)
      TX_IDLE: begin
        if (!fifo_empty && !tx_busy) begin
          fifo_pop   = 1'b1;
          state_next = TX_SEND;
        end
      end
      TX_SEND: begin
        tx_send       = 1'b1;
        wait_cnt_next = '0;
        state_next    = TX_WAIT_BUSY;
      end
      TX_WAIT_BUSY: begin
        if (tx_busy) begin
          state_next = TX_WAIT_DONE;
        end else if (wait_cnt == TIMEOUT_W'(BUSY_TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_next  = TX_IDLE;
        end else begin
          wait_cnt_next = wait_cnt + 1'b1;
        end
      end
      TX_WAIT_DONE: begin
        if (!tx_busy) state_next = TX_IDLE;
      end
      default: state_next = TX_IDLE;
    endcase
  end

  assign tx_state = state;

endmodule

// File: tb/tb_nonce_tx_arbiter.sv
// Directed bench for nonce_tx_arbiter: latency, adjustment wrap, round-robin
// order, full FIFO with drops, missed strobe timeout and reset mid-transmit.
module tb_nonce_tx_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // main DUT, NONCE_ADJ = 0
  logic [3:0]   nonce_vld;
  logic [127:0] nonce_in;
  logic         tx_busy;
  logic         tx_send;
  logic [31:0]  tx_word;
  logic         overflow;
  logic [3:0]   fifo_count;
  logic [1:0]   tx_state;

  // second DUT, NONCE_ADJ = 5, busy tied low
  logic [3:0]   a_vld;
  logic [127:0] a_in;
  logic         a_busy;
  logic         a_send;
  logic [31:0]  a_word;
  logic         a_ovf;
  logic [3:0]   a_count;
  logic [1:0]   a_state;

  logic stuck_busy;
  logic model_busy;
  logic model_en;
  assign tx_busy = stuck_busy | model_busy;

  int compared   = 0;
  int mismatched = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic prev_send = 1'b0;

  nonce_tx_arbiter #(.NUM_CORES(4), .FIFO_DEPTH(8), .NONCE_ADJ(32'd0)) dut (
    .clk(clk), .reset(reset), .nonce_vld(nonce_vld), .nonce_in(nonce_in),
    .tx_busy(tx_busy), .tx_send(tx_send), .tx_word(tx_word),
    .overflow(overflow), .fifo_count(fifo_count), .tx_state(tx_state)
  );

  nonce_tx_arbiter #(.NUM_CORES(4), .FIFO_DEPTH(8), .NONCE_ADJ(32'd5)) dut_adj (
    .clk(clk), .reset(reset), .nonce_vld(a_vld), .nonce_in(a_in),
    .tx_busy(a_busy), .tx_send(a_send), .tx_word(a_word),
    .overflow(a_ovf), .fifo_count(a_count), .tx_state(a_state)
  );

  // serial_transmit stand-in: busy rises one cycle after send, lasts 6 cycles
  initial begin
    model_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (model_en && tx_send) begin
        @(posedge clk); #1 model_busy = 1'b1;
        repeat (6) @(posedge clk);
        #1 model_busy = 1'b0;
      end
    end
  end

  // word collector; send must never last more than one cycle
  initial begin
    forever begin
      @(negedge clk);
      if (tx_send) begin
        got_q.push_back(tx_word);
        compared++;
        if (prev_send) begin
          mismatched++;
          $display("FAIL send_width: tx_send high on consecutive cycles, required single-cycle strobe");
        end
      end
      prev_send = tx_send;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic wait_words(input int n, input int budget, output bit ok);
    int cyc = 0;
    while (got_q.size() < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    ok = (got_q.size() >= n);
  endtask

  task automatic wait_quiet(input int budget, output bit ok);
    int cyc = 0;
    while (!(tx_state == 2'd0 && tx_busy == 1'b0) && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    ok = (tx_state == 2'd0 && tx_busy == 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    compared++; if (tx_send !== 1'b0) begin mismatched++; $display("FAIL reset_send: got %0b, required 0", tx_send); end
    compared++; if (tx_word !== 32'h0) begin mismatched++; $display("FAIL reset_word: got %h, required 00000000", tx_word); end
    compared++; if (overflow !== 1'b0) begin mismatched++; $display("FAIL reset_ovf: got %0b, required 0", overflow); end
    compared++; if (fifo_count !== 4'd0) begin mismatched++; $display("FAIL reset_count: got %0d, required 0", fifo_count); end
    compared++; if (tx_state !== 2'd0) begin mismatched++; $display("FAIL reset_state: got %0d, required 0", tx_state); end
  endtask

  task automatic test_single_nonce();
    bit ok;
    got_q.delete();
    @(posedge clk); #1 nonce_vld = 4'b0100; nonce_in[64 +: 32] = 32'h12345678;
    @(posedge clk); #1 nonce_vld = 4'b0000;
    @(negedge clk);
    compared++; if (tx_send !== 1'b0 || fifo_count !== 4'd0) begin mismatched++; $display("FAIL single_k0: send=%0b count=%0d, required 0/0", tx_send, fifo_count); end
    @(negedge clk);
    compared++; if (tx_send !== 1'b0 || fifo_count !== 4'd1) begin mismatched++; $display("FAIL single_k1: send=%0b count=%0d, required 0/1", tx_send, fifo_count); end
    @(negedge clk);
    compared++; if (tx_send !== 1'b1 || tx_word !== 32'h12345678) begin mismatched++; $display("FAIL single_k2: send=%0b word=%h, required 1/12345678", tx_send, tx_word); end
    compared++; if (fifo_count !== 4'd0) begin mismatched++; $display("FAIL single_pop_count: got %0d, required 0", fifo_count); end
    @(negedge clk);
    compared++; if (tx_send !== 1'b0 || tx_state !== 2'd2) begin mismatched++; $display("FAIL single_k3: send=%0b state=%0d, required 0/2", tx_send, tx_state); end
    wait_quiet(40, ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL single_quiet: state=%0d busy=%0b, required idle", tx_state, tx_busy); end
    compared++; if (tx_word !== 32'h12345678) begin mismatched++; $display("FAIL single_hold: got %h, required 12345678", tx_word); end
    compared++; if (overflow !== 1'b0) begin mismatched++; $display("FAIL single_ovf: got %0b, required 0", overflow); end
    compared++; if (got_q.size() != 1) begin mismatched++; $display("FAIL single_count: got %0d words, required 1", got_q.size()); end
  endtask

  task automatic test_adj_wrap();
    int cyc;
    @(posedge clk); #1 a_vld = 4'b0001; a_in[31:0] = 32'h00000002;
    @(posedge clk); #1 a_vld = 4'b0000;
    cyc = 0;
    while (a_send !== 1'b1 && cyc < 10) begin @(negedge clk); cyc++; end
    compared++; if (a_send !== 1'b1 || a_word !== 32'hFFFFFFFD) begin mismatched++; $display("FAIL adj_wrap: send=%0b word=%h, required 1/fffffffd", a_send, a_word); end
    @(posedge clk); #1 a_vld = 4'b1000; a_in[96 +: 32] = 32'h00000010;
    @(posedge clk); #1 a_vld = 4'b0000;
    cyc = 0;
    while (a_send !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
    compared++; if (a_send !== 1'b1 || a_word !== 32'h0000000B) begin mismatched++; $display("FAIL adj_sub: send=%0b word=%h, required 1/0000000b", a_send, a_word); end
  endtask

  task automatic test_round_robin();
    bit ok;
    do_reset();
    got_q.delete(); exp_q.delete();
    exp_q = '{32'hA0000001, 32'hB0000002, 32'hC0000003, 32'hD0000004,
              32'hA1000011, 32'hB1000012, 32'hC1000013, 32'hD1000014};
    @(posedge clk); #1 nonce_vld = 4'b1111;
    nonce_in = {32'hD0000004, 32'hC0000003, 32'hB0000002, 32'hA0000001};
    @(posedge clk); #1 nonce_vld = 4'b0000;
    repeat (6) @(posedge clk);
    #1 nonce_vld = 4'b1111;
    nonce_in = {32'hD1000014, 32'hC1000013, 32'hB1000012, 32'hA1000011};
    @(posedge clk); #1 nonce_vld = 4'b0000;
    wait_words(8, 250, ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL rr_timeout: got %0d words, required 8", got_q.size()); end
    for (int i = 0; i < 8; i++) begin
      compared++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        mismatched++;
        $display("FAIL rr_order[%0d]: got %h, required %h", i, (i < got_q.size()) ? got_q[i] : 32'h0, exp_q[i]);
      end
    end
    compared++; if (overflow !== 1'b0) begin mismatched++; $display("FAIL rr_ovf: got %0b, required 0", overflow); end
    wait_quiet(40, ok);
  endtask

  task automatic test_full_fifo();
    bit ok;
    logic [31:0] v;
    stuck_busy = 1'b1;
    do_reset();
    got_q.delete(); exp_q.delete();
    @(posedge clk); #1;
    for (int p = 0; p < 12; p++) begin
      v = 32'hC0DE0000 + 32'(p);
      nonce_vld = 4'b0001 << (p % 4);
      nonce_in[32*(p % 4) +: 32] = v;
      exp_q.push_back(v);
      @(posedge clk); #1;
    end
    nonce_vld = 4'b0000;
    @(negedge clk);
    compared++; if (fifo_count !== 4'd8) begin mismatched++; $display("FAIL full_count: got %0d, required 8", fifo_count); end
    compared++; if (overflow !== 1'b0) begin mismatched++; $display("FAIL full_no_ovf: got %0b, required 0", overflow); end
    compared++; if (got_q.size() != 0) begin mismatched++; $display("FAIL full_no_send: got %0d words, required 0", got_q.size()); end
    @(posedge clk); #1 nonce_vld = 4'b0010; nonce_in[32 +: 32] = 32'hBAD00001;
    @(posedge clk); #1 nonce_vld = 4'b0000;
    @(negedge clk);
    compared++; if (overflow !== 1'b1) begin mismatched++; $display("FAIL full_drop_ovf: got %0b, required 1", overflow); end
    compared++; if (fifo_count !== 4'd8) begin mismatched++; $display("FAIL full_count_hold: got %0d, required 8", fifo_count); end
    stuck_busy = 1'b0;
    wait_words(12, 400, ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL full_drain_timeout: got %0d words, required 12", got_q.size()); end
    for (int i = 0; i < 12; i++) begin
      compared++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        mismatched++;
        $display("FAIL full_order[%0d]: got %h, required %h", i, (i < got_q.size()) ? got_q[i] : 32'h0, exp_q[i]);
      end
    end
    wait_quiet(40, ok);
    repeat (10) @(negedge clk);
    compared++; if (got_q.size() != 12) begin mismatched++; $display("FAIL full_total: got %0d words, required 12", got_q.size()); end
  endtask

  task automatic test_missed_strobe();
    model_en = 1'b0;
    do_reset();
    got_q.delete();
    @(posedge clk); #1 nonce_vld = 4'b0011;
    nonce_in[31:0] = 32'hAAAA0001; nonce_in[63:32] = 32'h55550002;
    @(posedge clk); #1 nonce_vld = 4'b0000;
    repeat (3) @(negedge clk);
    compared++; if (tx_send !== 1'b1 || tx_word !== 32'hAAAA0001) begin mismatched++; $display("FAIL miss_first: send=%0b word=%h, required 1/aaaa0001", tx_send, tx_word); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      compared++; if (tx_state !== 2'd2) begin mismatched++; $display("FAIL miss_wait[%0d]: state=%0d, required 2", i, tx_state); end
    end
    compared++; if (overflow !== 1'b0) begin mismatched++; $display("FAIL miss_ovf_early: got %0b, required 0", overflow); end
    @(negedge clk);
    compared++; if (tx_state !== 2'd0 || overflow !== 1'b1) begin mismatched++; $display("FAIL miss_timeout: state=%0d ovf=%0b, required 0/1", tx_state, overflow); end
    @(negedge clk);
    compared++; if (tx_send !== 1'b1 || tx_word !== 32'h55550002) begin mismatched++; $display("FAIL miss_next: send=%0b word=%h, required 1/55550002", tx_send, tx_word); end
    repeat (10) @(negedge clk);
    model_en = 1'b1;
  endtask

  task automatic test_reset_mid_transmit();
    bit ok;
    int cyc;
    do_reset();
    got_q.delete();
    @(posedge clk); #1 nonce_vld = 4'b1111;
    nonce_in = {32'hE0000003, 32'hE0000002, 32'hE0000001, 32'hE0000000};
    @(posedge clk); #1 nonce_vld = 4'b0000;
    cyc = 0;
    while (tx_state !== 2'd3 && cyc < 20) begin @(negedge clk); cyc++; end
    compared++; if (tx_state !== 2'd3 || fifo_count !== 4'd3) begin mismatched++; $display("FAIL mid_setup: state=%0d count=%0d, required 3/3", tx_state, fifo_count); end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    compared++; if (tx_send !== 1'b0 || fifo_count !== 4'd0) begin mismatched++; $display("FAIL mid_reset: send=%0b count=%0d, required 0/0", tx_send, fifo_count); end
    compared++; if (tx_state !== 2'd0) begin mismatched++; $display("FAIL mid_reset_state: got %0d, required 0", tx_state); end
    wait_quiet(40, ok);
    repeat (20) @(negedge clk);
    compared++; if (got_q.size() != 1) begin mismatched++; $display("FAIL mid_pend_clear: got %0d words, required 1", got_q.size()); end
    @(posedge clk); #1 nonce_vld = 4'b1000; nonce_in[96 +: 32] = 32'h0F0F1234;
    @(posedge clk); #1 nonce_vld = 4'b0000;
    repeat (3) @(negedge clk);
    compared++; if (tx_send !== 1'b1 || tx_word !== 32'h0F0F1234) begin mismatched++; $display("FAIL mid_fresh: send=%0b word=%h, required 1/0f0f1234", tx_send, tx_word); end
    wait_quiet(40, ok);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    nonce_vld = '0; nonce_in = '0;
    a_vld = '0; a_in = '0; a_busy = 1'b0;
    stuck_busy = 1'b0; model_en = 1'b1;
    test_reset();
    test_single_nonce();
    test_adj_wrap();
    test_round_robin();
    test_full_fifo();
    test_missed_strobe();
    test_reset_mid_transmit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
